mem_uart_dumper: RTL and testbench
==================================

// Module: mem_uart_dumper
// PURPOSE
//  Downstream consumer of the processor's data-memory debug port (port B: address, wren_b, q_b).
//  On a start pulse it reads LENGTH consecutive bytes from BASE, one byte at a time, through that port.
//  Each byte is sent LSB-first on a UART 8N1 line, so a host can dump program results after a run.
//  Sits beside the processor at top level and owns port B while busy.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per UART bit (50 MHz / 115200); legal range >= 2
//  RD_LAT        1    data-memory port-B read latency in cycles (address edge to q valid); legal 1..2
//  LEN_W         16   width of the byte-count input
// PORTS
//  clk          in   1      system clock; all logic on rising edge
//  rst          in   1      synchronous reset, active-high
//  start        in   1      begin a dump; sampled only in IDLE
//  base_addr    in   32     first byte address; latched on accepted start
//  length       in   LEN_W  number of bytes to send; latched on accepted start
//  mem_address  out  32     to data-memory port B address
//  mem_wren     out  1      to data-memory port B write enable; constant 0
//  mem_q        in   8      from data-memory port B read data
//  uart_tx      out  1      serial output; idle high
//  busy         out  1      high from the cycle after an accepted start until done
//  done         out  1      one-cycle pulse when the dump ends
// BEHAVIOUR
//  Reset values: mem_address=0, mem_wren=0, uart_tx=1, busy=0, done=0, FSM=IDLE, all counters cleared.
//  FSM states: IDLE, FETCH, START, DATA, STOP, FIN.
//  IDLE: on edge with start=1:
//   - latch addr<=base_addr and rem<=length
//   - if length==0, go to FIN; else go to FETCH with mem_address<=base_addr
//  FETCH: lasts RD_LAT+1 cycles with mem_address stable.
//   - On the last FETCH edge, shift register <= mem_q; go to START.
//  START: uart_tx=0 for CLKS_PER_BIT cycles.
//  DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
//  STOP: uart_tx=1 for CLKS_PER_BIT cycles. At the end: rem<=rem-1, addr<=addr+1 (mod 2^32).
//   - If rem-1 != 0, go to FETCH with mem_address<=addr+1; else go to FIN.
//  FIN: one cycle; done=1 and busy=0 in this cycle. Then go to IDLE.
//  uart_tx is registered; outside START/DATA it is 1.
//  Byte period = RD_LAT+1+10*CLKS_PER_BIT cycles. Consecutive frames have no idle gap beyond FETCH.
//  Start level is ignored while busy or in FIN. A held start re-triggers only from IDLE.
//  base_addr/length changes after acceptance have no effect.
//  mem_address wraps 0xFFFFFFFF -> 0x00000000 silently.
//  length = 2^LEN_W-1 must complete without counter overflow.
//  rst mid-dump: next edge gives reset values (line high at once, truncated frame allowed), no done pulse.
//  mem_wren never asserts; host-side writes to port B while busy are out of scope.
// TESTING (CLKS_PER_BIT=4, RD_LAT=1, single-cycle-latency RAM model)
//  1. mem[0x10]=0xA5, start with base=0x10, length=1:
//     -> tx low 4 cycles, bits 1,0,1,0,0,1,0,1 (4 cycles each), high 4;
//     -> done exactly 42 cycles after busy rises.
//  2. mem[0x20..0x22]=0x01,0x80,0xFF, length=3:
//     -> three back-to-back frames, 42-cycle spacing;
//     -> mem_address steps 0x20,0x21,0x22; one done pulse total.
//  3. length=0:
//     -> done pulses on the 2nd cycle after the start edge;
//     -> uart_tx stays 1 and mem_address is unchanged.
//  4. base=0xFFFFFFFF, length=2:
//     -> mem_address reads 0xFFFFFFFF then 0x00000000;
//     -> bytes match mem contents at those addresses.
//  5. start pulsed again mid-dump:
//     -> ignored; frame count, spacing and single done unchanged.
//  6. rst asserted during DATA bit 3:
//     -> next cycle uart_tx=1, busy=0, mem_address=0, no done;
//     -> a fresh start afterwards produces a correct frame.

Source files
------------

// File: rtl/mem_uart_dumper_if.sv
// Data-memory port-B debug bus between the UART dumper (master) and the RAM (slave).
// The master drives address and write enable; the RAM returns read data.
interface mem_uart_dumper_if;
   logic [31:0] mem_address;
   logic        mem_wren;
   logic [7:0]  mem_q;

   modport master (output mem_address, output mem_wren, input mem_q);
   modport slave  (input mem_address, input mem_wren, output mem_q);
endinterface

// File: rtl/mem_uart_dumper.sv
// Reads a block of bytes from data-memory port B and streams them out as UART 8N1 frames.
// The status outputs and the serial line are registered from the current state, so they trail the FSM by one cycle.
module mem_uart_dumper #(
   parameter int CLKS_PER_BIT = 434,
   parameter int RD_LAT       = 1,
   parameter int LEN_W        = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [31:0]          base_addr,
   input  logic [LEN_W-1:0]     length,
   mem_uart_dumper_if.master    mem,
   output logic                 uart_tx,
   output logic                 busy,
   output logic                 done
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ZERO  = {BAUD_W{1'b0}};
   localparam logic [1:0]        FETCH_LAST = 2'(RD_LAT);
   localparam logic [LEN_W-1:0]  LEN_ZERO   = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0]  LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_START = 3'd2,
      S_DATA  = 3'd3,
      S_STOP  = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [BAUD_W-1:0] baud_cnt_r;
   logic [BAUD_W-1:0] baud_next_s;
   logic [2:0]        bit_idx_r;
   logic [1:0]        fetch_cnt_r;
   logic [7:0]        shift_r;
   logic [31:0]       addr_r;
   logic [LEN_W-1:0]  rem_r;
   logic [31:0]       mem_address_r;
   logic              tx_r;
   logic              busy_r;
   logic              done_r;
   logic              baud_end_s;
   logic              fetch_end_s;
   logic              last_byte_s;

   assign baud_end_s  = (baud_cnt_r == BAUD_LAST);
   assign fetch_end_s = (fetch_cnt_r == FETCH_LAST);
   assign last_byte_s = (rem_r == LEN_ONE);

   assign mem.mem_address = mem_address_r;
   assign mem.mem_wren    = 1'b0;
   assign uart_tx         = tx_r;
   assign busy            = busy_r;
   assign done            = done_r;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode and bit-timer increment
   always_comb begin
      state_s     = state_r;
      baud_next_s = BAUD_ZERO;
      if (baud_end_s) begin
         baud_next_s = BAUD_ZERO;
      end else begin
         baud_next_s = baud_cnt_r + {{(BAUD_W-1){1'b0}}, 1'b1};
      end
      case (state_r)
         S_IDLE: begin
            if (start) begin
               if (length == LEN_ZERO) begin
                  state_s = S_FIN;
               end else begin
                  state_s = S_FETCH;
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_FETCH: begin
            if (fetch_end_s) begin
               state_s = S_START;
            end else begin
               state_s = S_FETCH;
            end
         end
         S_START: begin
            if (baud_end_s) begin
               state_s = S_DATA;
            end else begin
               state_s = S_START;
            end
         end
         S_DATA: begin
            if (baud_end_s && (bit_idx_r == 3'd7)) begin
               state_s = S_STOP;
            end else begin
               state_s = S_DATA;
            end
         end
         S_STOP: begin
            if (!baud_end_s) begin
               state_s = S_STOP;
            end else if (last_byte_s) begin
               state_s = S_FIN;
            end else begin
               state_s = S_FETCH;
            end
         end
         S_FIN:   state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // Datapath: address/remaining count, fetch wait, bit timer and shifter
   always_ff @(posedge clk) begin
      if (rst) begin
         baud_cnt_r    <= BAUD_ZERO;
         bit_idx_r     <= 3'd0;
         fetch_cnt_r   <= 2'd0;
         shift_r       <= 8'd0;
         addr_r        <= 32'd0;
         rem_r         <= LEN_ZERO;
         mem_address_r <= 32'd0;
      end else begin
         case (state_r)
            S_IDLE: begin
               baud_cnt_r  <= BAUD_ZERO;
               bit_idx_r   <= 3'd0;
               fetch_cnt_r <= 2'd0;
               if (start) begin
                  addr_r <= base_addr;
                  rem_r  <= length;
                  if (length != LEN_ZERO) begin
                     mem_address_r <= base_addr;
                  end
               end
            end
            S_FETCH: begin
               if (fetch_end_s) begin
                  shift_r     <= mem.mem_q;
                  fetch_cnt_r <= 2'd0;
               end else begin
                  fetch_cnt_r <= fetch_cnt_r + 2'd1;
               end
            end
            S_START: baud_cnt_r <= baud_next_s;
            S_DATA: begin
               baud_cnt_r <= baud_next_s;
               if (baud_end_s) begin
                  shift_r   <= {1'b0, shift_r[7:1]};
                  bit_idx_r <= bit_idx_r + 3'd1;
               end
            end
            S_STOP: begin
               baud_cnt_r <= baud_next_s;
               // Count down from the latched length so 2^LEN_W-1 bytes never overflow.
               if (baud_end_s) begin
                  rem_r  <= rem_r - LEN_ONE;
                  addr_r <= addr_r + 32'd1;
                  if (!last_byte_s) begin
                     mem_address_r <= addr_r + 32'd1;
                  end
               end
            end
            default: begin
               baud_cnt_r  <= BAUD_ZERO;
               bit_idx_r   <= 3'd0;
               fetch_cnt_r <= 2'd0;
            end
         endcase
      end
   end

   // Registered serial line and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_r   <= 1'b1;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state_r)
            S_START: begin
               tx_r   <= 1'b0;
               busy_r <= 1'b1;
               done_r <= 1'b0;
            end
            S_DATA: begin
               tx_r   <= shift_r[0];
               busy_r <= 1'b1;
               done_r <= 1'b0;
            end
            S_FETCH, S_STOP: begin
               tx_r   <= 1'b1;
               busy_r <= 1'b1;
               done_r <= 1'b0;
            end
            S_FIN: begin
               tx_r   <= 1'b1;
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
            default: begin
               tx_r   <= 1'b1;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_uart_dumper.sv
// Directed bench for mem_uart_dumper with CLKS_PER_BIT=4, RD_LAT=1 and a one-cycle RAM model.
// Cycle k counts falling edges after the start-accepting rising edge; frames repeat every 42 cycles.
module tb_mem_uart_dumper;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] base_addr;
   logic [15:0] length;
   logic        uart_tx;
   logic        busy;
   logic        done;
   logic [7:0]  ram [0:255];
   int          vec_cnt;
   int          err_cnt;

   mem_uart_dumper_if mem_bus ();

   mem_uart_dumper #(
      .CLKS_PER_BIT (4),
      .RD_LAT       (1),
      .LEN_W        (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .mem       (mem_bus),
      .uart_tx   (uart_tx),
      .busy      (busy),
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single-cycle-latency RAM on port B, indexed by the low address byte
   always @(posedge clk) begin
      mem_bus.mem_q <= ram[mem_bus.mem_address[7:0]];
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected line level at cycle k for a dump of len bytes (bytes packed LSB-first in eb)
   function automatic logic exp_tx(input int k, input int len, input logic [23:0] eb);
      int         j;
      int         pos;
      logic [7:0] b;
      exp_tx = 1'b1;
      if (len > 0 && k >= 4) begin
         j   = (k - 4) / 42;
         pos = (k - 4) % 42;
         if (j < len) begin
            if (pos < 4) begin
               exp_tx = 1'b0;
            end else if (pos < 36) begin
               b      = eb[8*j +: 8];
               exp_tx = b[(pos - 4) / 4];
            end
         end
      end
   endfunction

   task automatic run_dump(input string tag, input logic [31:0] base, input int len,
                           input int repulse_k, input logic [23:0] eb);
      int          ncyc;
      int          tx_bad;
      int          busy_bad;
      int          done_bad;
      int          addr_bad;
      int          wren_bad;
      int          done_cnt;
      int          j;
      int          pos;
      logic        exp_busy;
      logic        exp_done;
      logic [31:0] addr0;
      logic [7:0]  got [0:2];
      tx_bad   = 0;
      busy_bad = 0;
      done_bad = 0;
      addr_bad = 0;
      wren_bad = 0;
      done_cnt = 0;
      for (int i = 0; i < 3; i++) got[i] = 8'h00;
      addr0     = mem_bus.mem_address;
      base_addr = base;
      length    = 16'(len);
      start     = 1'b1;
      ncyc      = len * 42 + 12;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (uart_tx !== exp_tx(k, len, eb)) tx_bad++;
         exp_busy = (len > 0) && (k >= 2) && (k <= 1 + 42 * len);
         exp_done = (k == 2 + 42 * len);
         if (busy !== exp_busy) busy_bad++;
         if (done !== exp_done) done_bad++;
         if (done === 1'b1) done_cnt++;
         if (mem_bus.mem_wren !== 1'b0) wren_bad++;
         if (len == 0) begin
            if (mem_bus.mem_address !== addr0) addr_bad++;
         end else if (k >= 2 && ((k - 2) % 42) == 0 && ((k - 2) / 42) < len) begin
            if (mem_bus.mem_address !== base + 32'((k - 2) / 42)) addr_bad++;
         end
         if (len > 0 && k >= 4) begin
            j   = (k - 4) / 42;
            pos = (k - 4) % 42;
            if (j < len && pos >= 4 && pos < 36 && (pos % 4) == 2) got[j][(pos - 4) / 4] = uart_tx;
         end
         // Inputs change after acceptance; they must not affect the dump in progress.
         start     = (k == repulse_k);
         base_addr = 32'h0000_0040;
         length    = 16'd7;
      end
      start = 1'b0;
      check_val({tag, "_tx_cycles"},   32'(tx_bad),   32'd0);
      check_val({tag, "_busy_cycles"}, 32'(busy_bad), 32'd0);
      check_val({tag, "_done_cycles"}, 32'(done_bad), 32'd0);
      check_val({tag, "_done_count"},  32'(done_cnt), 32'd1);
      check_val({tag, "_addr"},        32'(addr_bad), 32'd0);
      check_val({tag, "_wren"},        32'(wren_bad), 32'd0);
      for (int i = 0; i < len; i++) begin
         check_val({tag, "_byte"}, {24'd0, got[i]}, {24'd0, eb[8*i +: 8]});
      end
   endtask

   initial begin
      int bad;
      vec_cnt   = 0;
      err_cnt   = 0;
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = 32'd0;
      length    = 16'd0;
      for (int i = 0; i < 256; i++) ram[i] = 8'(i);
      ram[8'h10] = 8'hA5;
      ram[8'h20] = 8'h01;
      ram[8'h21] = 8'h80;
      ram[8'h22] = 8'hFF;
      ram[8'hFF] = 8'h3C;
      ram[8'h00] = 8'hC3;

      repeat (3) @(negedge clk);
      check_val("rst_tx",   {31'd0, uart_tx},          32'd1);
      check_val("rst_busy", {31'd0, busy},             32'd0);
      check_val("rst_done", {31'd0, done},             32'd0);
      check_val("rst_addr", mem_bus.mem_address,       32'd0);
      check_val("rst_wren", {31'd0, mem_bus.mem_wren}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_dump("t1_single", 32'h0000_0010, 1, 0, 24'h0000A5);
      run_dump("t2_three",  32'h0000_0020, 3, 0, 24'hFF8001);
      run_dump("t3_zero",   32'h0000_0030, 0, 0, 24'h000000);
      run_dump("t4_wrap",   32'hFFFF_FFFF, 2, 0, 24'h00C33C);
      run_dump("t5_restart", 32'h0000_0020, 3, 50, 24'hFF8001);

      // Reset in the middle of data bit 3 of an 0xA5 frame (bit 3 is a 0 on the line)
      base_addr = 32'h0000_0010;
      length    = 16'd1;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check_val("t6_pre_tx",   {31'd0, uart_tx}, 32'd0);
      check_val("t6_pre_busy", {31'd0, busy},    32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_val("t6_rst_tx",   {31'd0, uart_tx},    32'd1);
      check_val("t6_rst_busy", {31'd0, busy},       32'd0);
      check_val("t6_rst_addr", mem_bus.mem_address, 32'd0);
      check_val("t6_rst_done", {31'd0, done},       32'd0);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0 || uart_tx !== 1'b1) bad++;
      end
      check_val("t6_quiet", 32'(bad), 32'd0);
      run_dump("t6_fresh", 32'h0000_0010, 1, 0, 24'h0000A5);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
